// File: rtl/clk_control_divider_if.sv
// rtl/clk_control_divider_if.sv - Register-bank side of the programmable clock-enable divider
interface clk_control_divider_if #(
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 16
);
    logic [3:0]           cfg_wr_en;
    logic [31:0]          cfg_ctrl;
    logic [DIV_WIDTH-1:0] cfg_div;
    logic [CNT_WIDTH-1:0] cfg_burst;
    logic                 clk_en_o;
    logic                 irq_o;
    logic [31:0]          status_o;

    modport master (
        output cfg_wr_en, cfg_ctrl, cfg_div, cfg_burst,
        input  clk_en_o, irq_o, status_o
    );

    modport slave (
        input  cfg_wr_en, cfg_ctrl, cfg_div, cfg_burst,
        output clk_en_o, irq_o, status_o
    );
endinterface

// File: rtl/clk_control_divider.sv
// rtl/clk_control_divider.sv - Divided single-cycle clock-enable with free-run and burst modes
module clk_control_divider #(
    parameter int DIV_WIDTH = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 ACLK,
    input  logic                 ARESETN,
    clk_control_divider_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t               state, nxt_state;
    logic [DIV_WIDTH-1:0] phase, nxt_phase;
    logic [DIV_WIDTH-1:0] active_div, nxt_active_div;
    logic [DIV_WIDTH-1:0] pending_div, nxt_pending_div;
    logic                 div_pending, nxt_div_pending;
    logic [CNT_WIDTH-1:0] remaining, nxt_remaining;
    logic [CNT_WIDTH-1:0] pulse_count, nxt_pulse_count;
    logic                 done, nxt_done;
    logic                 burst_mode, nxt_burst_mode;
    logic                 enter_done;

    logic ctrl_wr, div_wr, start, stop, pulse;
    logic unused_bits;

    // A multi-hot strobe is treated as a ctrl write only.
    assign ctrl_wr     = bus.cfg_wr_en[0];
    assign div_wr      = bus.cfg_wr_en[1] && !bus.cfg_wr_en[0];
    assign start       = ctrl_wr && bus.cfg_ctrl[0];
    assign stop        = ctrl_wr && !bus.cfg_ctrl[0];
    assign pulse       = (state == RUN) && (phase == active_div);
    assign unused_bits = ^{bus.cfg_ctrl[31:2], bus.cfg_wr_en[3:2]};

    always_comb begin
        nxt_state       = state;
        nxt_phase       = phase;
        nxt_active_div  = active_div;
        nxt_pending_div = pending_div;
        nxt_div_pending = div_pending;
        nxt_remaining   = remaining;
        nxt_pulse_count = pulse_count;
        nxt_done        = done;
        nxt_burst_mode  = burst_mode;
        enter_done      = 1'b0;

        if (start) begin
            nxt_active_div  = bus.cfg_div;
            nxt_remaining   = bus.cfg_burst;
            nxt_pulse_count = '0;
            nxt_done        = 1'b0;
            nxt_phase       = '0;
            nxt_div_pending = 1'b0;
            nxt_burst_mode  = bus.cfg_ctrl[1];
            if (bus.cfg_ctrl[1] && (bus.cfg_burst == '0)) begin
                nxt_state  = DONE;
                nxt_done   = 1'b1;
                enter_done = 1'b1;
            end else begin
                nxt_state = RUN;
            end
        end else if (stop) begin
            if (state == DONE) begin
                nxt_state = IDLE;
                nxt_done  = 1'b0;
            end else if (state == RUN) begin
                // A pulse already on the output in the stop cycle is still counted.
                nxt_state       = IDLE;
                nxt_div_pending = 1'b0;
                if (pulse) begin
                    nxt_pulse_count = pulse_count + CNT_WIDTH'(1);
                end
            end
        end else if (state == RUN) begin
            if (div_wr) begin
                nxt_pending_div = bus.cfg_div;
                nxt_div_pending = 1'b1;
            end
            if (pulse) begin
                nxt_phase       = '0;
                nxt_pulse_count = pulse_count + CNT_WIDTH'(1);
                // A divisor written in the pulse cycle itself waits for the next pulse.
                if (div_pending && !div_wr) begin
                    nxt_active_div  = pending_div;
                    nxt_div_pending = 1'b0;
                end
                if (burst_mode) begin
                    nxt_remaining = remaining - CNT_WIDTH'(1);
                    if (remaining == CNT_WIDTH'(1)) begin
                        nxt_state       = DONE;
                        nxt_done        = 1'b1;
                        nxt_div_pending = 1'b0;
                        enter_done      = 1'b1;
                    end
                end
            end else begin
                nxt_phase = phase + DIV_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state        <= IDLE;
            phase        <= '0;
            active_div   <= '0;
            pending_div  <= '0;
            div_pending  <= 1'b0;
            remaining    <= '0;
            pulse_count  <= '0;
            done         <= 1'b0;
            burst_mode   <= 1'b0;
            bus.clk_en_o <= 1'b0;
            bus.irq_o    <= 1'b0;
            bus.status_o <= '0;
        end else begin
            state        <= nxt_state;
            phase        <= nxt_phase;
            active_div   <= nxt_active_div;
            pending_div  <= nxt_pending_div;
            div_pending  <= nxt_div_pending;
            remaining    <= nxt_remaining;
            pulse_count  <= nxt_pulse_count;
            done         <= nxt_done;
            burst_mode   <= nxt_burst_mode;
            // Output is registered from next-state so the enable lands in the cycle phase==divisor.
            bus.clk_en_o <= (nxt_state == RUN) && (nxt_phase == nxt_active_div);
            bus.irq_o    <= enter_done;
            bus.status_o <= {16'(pulse_count), 12'h000, div_pending, done, state};
        end
    end
endmodule

// File: doc/clk_control_divider.md
# clk_control_divider

Programmable clock-enable generator fed by the clk_control AXI4-Lite register bank (S00_AXI, slave registers 0–3). It consumes register values and write strobes, and produces a divided single-cycle clock-enable pulse with free-run and burst modes. It returns a status word to slave register 3 and raises an interrupt pulse when a burst completes.

## Interface
- DIV_WIDTH, 16, width of divisor field (≤ 32)
- CNT_WIDTH, 16, width of burst length and pulse counter (≤ 16)

- ACLK  in  1  system clock; all logic rising-edge
- ARESETN  in  1  asynchronous, active-low reset
- cfg_wr_en  in  4  one-hot, one-cycle strobe: slave register n written this cycle
- cfg_ctrl  in  32  reg0: bit0 enable, bit1 mode (0 free-run, 1 burst)
- cfg_div  in  DIV_WIDTH  reg1: divisor; period = cfg_div+1 cycles
- cfg_burst  in  CNT_WIDTH  reg2: pulse count in burst mode
- clk_en_o  out  1  divided enable, one cycle high per period
- irq_o  out  1  one-cycle pulse on entry to DONE
- status_o  out  32  to reg3 read path: [1:0] state (00 IDLE, 01 RUN, 10 DONE), [2] done sticky, [3] div_pending, [31:16] pulse_count (zero-extended)

## Operation
- Reset (ARESETN low, async) forces: state IDLE, phase 0, active_div 0, pending 0, remaining 0, pulse_count 0, done 0, clk_en_o 0, irq_o 0, status_o 0.
- IDLE: clk_en_o 0.
  - A ctrl write with bit0=1 loads active_div←cfg_div, remaining←cfg_burst, pulse_count←0, done←0, phase←0, then goes to RUN.
  - If mode=1 and cfg_burst=0, it goes directly to DONE instead (no pulses; done←1; irq_o pulse).
- RUN: phase increments each cycle.
  - When phase==active_div, clk_en_o=1 that cycle, phase←0, and pulse_count increments (wraps modulo 2^CNT_WIDTH).
  - active_div=0 means clk_en_o is high every cycle.
- Burst mode: remaining decrements on each pulse. On the pulse where remaining==1, the next state is DONE.
- DONE: clk_en_o 0, done=1, pulse_count held.
  - A ctrl write with bit0=1 restarts exactly as from IDLE.
  - A ctrl write with bit0=0 goes to IDLE, done←0.
- Stop: a ctrl write with bit0=0 during RUN goes to IDLE next cycle. clk_en_o is 0 from that cycle on. pulse_count is held. done is unchanged.
- Divisor update during RUN:
  - A reg1 write latches pending_div←cfg_div and sets div_pending.
  - The pending value is applied (active_div←pending_div, div_pending←0) on the cycle of the next pulse, so the following period uses the new value.
  - A second write before that pulse overwrites pending_div.
- Divisor update outside RUN: a reg1 write is ignored; start samples cfg_div directly.
- Reg2/reg3 writes outside start have no effect. The mode bit is sampled only at start.
- Ctrl writes with bit0=1 while in RUN restart the channel: phase←0, counters reloaded, pending cleared.
- Simultaneous events:
  - Stop write on the same cycle as the final burst pulse: the pulse is emitted, stop wins, next state IDLE, done stays 0, no irq.
  - Start write with a reg1 strobe in the same cycle: impossible (cfg_wr_en is one-hot). Treat multi-hot input as reg0 only.
- Reset mid-operation: immediate return to reset values. No trailing pulse and no irq.

## Timing
- A ctrl start write sampled at edge T gives state RUN from cycle T+1.
- First clk_en_o high in cycle T+1+div. Subsequent pulses every div+1 cycles.
- clk_en_o and irq_o are driven directly from flops (glitch-free, no combinational path from inputs).
- irq_o is high in the first DONE cycle only.
- status_o is registered and reflects state/counters one cycle after they change. Read latency through the register bank is unaffected.
- Stop sampled at edge T: no clk_en_o in cycle T+1 or later.

## Test plan
- Free-run: div=3, start at T → clk_en_o high at T+4, T+8, T+12. status_o[31:16] reads 3 after the third pulse. status_o[1:0]=01.
- Burst: div=1, burst=3, mode=1 → pulses at T+2, T+4, T+6. DONE at T+7 with irq_o=1 for one cycle. status_o=0x0003_0006.
- Divisor change: div=3 running; write div=1 between the pulses at T+4 and T+8 → pulses at T+8 (old period), then T+10, T+12. div_pending is 1 until T+8.
- Stop on final pulse: burst=2, div=0; stop write sampled at the second pulse edge → exactly 2 pulses, state IDLE, done=0, irq_o never high.
- Burst of zero: mode=1, burst=0 → DONE at T+1, irq_o pulse, no clk_en_o, status_o=0x0000_0006.
- Reset mid-run: assert ARESETN low asynchronously between clock edges during RUN with div=5 → clk_en_o, irq_o and status_o go to 0 immediately. After release there are no pulses until a new start.
